// File: rtl/adc_frame_uart_pkg.sv
// Shared constants, state encodings and frame-byte helper for the ADC-to-host UART framer.
package adc_frame_uart_pkg;

    localparam int unsigned FRAME_LEN      = 6;
    localparam int unsigned BITS_PER_BYTE  = 10;
    localparam int unsigned CH_W           = 12;
    localparam int unsigned BAUD_W         = 10;
    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_SEND = 2'd1,
        FR_DONE = 2'd2
    } fr_state_e;

    typedef struct packed {
        logic [CH_W-1:0] ch0;
        logic [CH_W-1:0] ch1;
    } snapshot_t;

    // Byte idx of the frame: header, ch0 hi/lo, ch1 hi/lo, XOR checksum.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [7:0] hdr,
                                              input snapshot_t  s);
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] b4;
        logic [7:0] res;
        b1 = {4'h0, s.ch0[11:8]};
        b2 = s.ch0[7:0];
        b3 = {4'h0, s.ch1[11:8]};
        b4 = s.ch1[7:0];
        case (idx)
            3'd0:    res = hdr;
            3'd1:    res = b1;
            3'd2:    res = b2;
            3'd3:    res = b3;
            3'd4:    res = b4;
            default: res = hdr ^ b1 ^ b2 ^ b3 ^ b4;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; done_o marks the final cycle of the stop bit so the
// next byte can be chained with no idle gap by raising start_i in that cycle.
module uart_tx_byte
    import adc_frame_uart_pkg::*;
#(
    parameter int unsigned BaudDiv = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BaudDiv - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BaudDiv - 2);

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              done_q;
    logic              bit_end_c;

    assign bit_end_c = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // Registered one cycle early so it lines up with the last stop-bit cycle.
            done_q <= (state_q == TX_STOP) && (baud_q == BAUD_PRE);
            case (state_q)
                TX_IDLE: begin
                    baud_q <= '0;
                    if (start_i) begin
                        state_q <= TX_START;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end_c) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= TX_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end_c) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end_c) begin
                        baud_q <= '0;
                        if (start_i) begin
                            state_q <= TX_START;
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign done_o = done_q;

endmodule

// File: rtl/adc_frame_uart.sv
// Snapshots both ADC channels on end-of-sequence and sends them to the host as a
// 6-byte UART frame: header, ch0 hi/lo, ch1 hi/lo, XOR checksum.
module adc_frame_uart
    import adc_frame_uart_pkg::*;
#(
    parameter int unsigned BaudDiv = 868,
    parameter logic [7:0]  Header  = HEADER_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eos_i,
    input  logic [11:0] doutch0_i,
    input  logic [11:0] doutch1_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        drop_o,
    output logic        frame_done_o
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

    fr_state_e  state_q;
    snapshot_t  snap_q;
    logic [2:0] byte_q;
    logic       busy_q;
    logic       drop_q;
    logic       frame_done_q;

    logic       start_c;
    logic       byte_done_c;
    logic [2:0] sel_c;
    logic [7:0] byte_c;

    // In IDLE the header goes out on the accepting edge; afterwards the next byte is
    // presented while the current stop bit finishes.
    always_comb begin
        sel_c   = 3'd0;
        start_c = 1'b0;
        if (state_q == FR_IDLE) begin
            start_c = eos_i;
        end else begin
            sel_c   = byte_q + 3'd1;
            start_c = (state_q == FR_SEND) && byte_done_c && (byte_q != LAST_BYTE);
        end
        byte_c = frame_byte(sel_c, Header, snap_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= FR_IDLE;
            snap_q       <= '0;
            byte_q       <= '0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            drop_q       <= eos_i && (state_q != FR_IDLE);
            frame_done_q <= 1'b0;
            case (state_q)
                FR_IDLE: begin
                    byte_q <= '0;
                    if (eos_i) begin
                        snap_q  <= '{ch0: doutch0_i, ch1: doutch1_i};
                        busy_q  <= 1'b1;
                        state_q <= FR_SEND;
                    end
                end
                FR_SEND: begin
                    if (byte_done_c) begin
                        if (byte_q == LAST_BYTE) begin
                            state_q      <= FR_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            byte_q <= byte_q + 3'd1;
                        end
                    end
                end
                FR_DONE: begin
                    state_q <= FR_IDLE;
                    busy_q  <= 1'b0;
                    byte_q  <= '0;
                end
                default: begin
                    state_q <= FR_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BaudDiv (BaudDiv)
    ) u_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_c),
        .data_i  (byte_c),
        .tx_o    (tx_o),
        .done_o  (byte_done_c)
    );

    assign busy_o       = busy_q;
    assign drop_o       = drop_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_adc_frame_uart.sv
// Directed bench for adc_frame_uart at BaudDiv=4: cycle-exact line checks plus byte decode.
module tb_adc_frame_uart;

    localparam int unsigned BD = 4;
    localparam int FRAME_CYC = 60 * BD;

    typedef struct {
        logic [11:0] ch0;
        logic [11:0] ch1;
        int          ovr_p;
        logic [7:0]  b [6];
    } vec_t;

    logic        clk;
    logic        rst;
    logic        eos;
    logic [11:0] ch0;
    logic [11:0] ch1;
    logic        tx;
    logic        busy;
    logic        drop;
    logic        fdone;

    int checks;
    int errors;

    vec_t vecs [5];

    adc_frame_uart #(
        .BaudDiv (BD),
        .Header  (8'hA5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .eos_i        (eos),
        .doutch0_i    (ch0),
        .doutch1_i    (ch1),
        .tx_o         (tx),
        .busy_o       (busy),
        .drop_o       (drop),
        .frame_done_o (fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] c0, input logic [11:0] c1, input int o,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        vec_t r;
        r.ch0 = c0;
        r.ch1 = c1;
        r.ovr_p = o;
        r.b[0] = b0;
        r.b[1] = b1;
        r.b[2] = b2;
        r.b[3] = b3;
        r.b[4] = b4;
        r.b[5] = b5;
        return r;
    endfunction

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Starts on a falling edge; eos is accepted on the next rising edge (period 1 follows it).
    task automatic run_frame(input vec_t v, input int fi);
        logic [9:0] obs [6];
        int k;
        int j;
        logic etx;
        for (int i = 0; i < 6; i++) obs[i] = '0;
        ch0 = v.ch0;
        ch1 = v.ch1;
        eos = 1'b1;
        for (int p = 1; p <= FRAME_CYC + 2; p++) begin
            @(negedge clk);
            if (p == 1) eos = 1'b0;
            k = (p - 1) / 40;
            j = ((p - 1) % 40) / BD;
            etx = (p <= FRAME_CYC) ? exp_bit(v.b[k], j) : 1'b1;
            chk($sformatf("f%0d.p%0d.tx", fi, p), 32'(tx), 32'(etx));
            chk($sformatf("f%0d.p%0d.busy", fi, p), 32'(busy), 32'(p <= FRAME_CYC + 1));
            chk($sformatf("f%0d.p%0d.frame_done", fi, p), 32'(fdone), 32'(p == FRAME_CYC + 1));
            chk($sformatf("f%0d.p%0d.drop", fi, p), 32'(drop),
                32'((v.ovr_p > 0) && (p == v.ovr_p + 1)));
            if (p <= FRAME_CYC && ((p - 1) % BD) == 2) obs[k][j] = tx;
            if (v.ovr_p > 0 && p == v.ovr_p) begin
                eos = 1'b1;
                ch0 = 12'hFFF;
                ch1 = 12'hFFF;
            end
            if (v.ovr_p > 0 && p == v.ovr_p + 1) eos = 1'b0;
        end
        for (int b = 0; b < 6; b++) begin
            chk($sformatf("f%0d.byte%0d.start", fi, b), 32'(obs[b][0]), 32'd0);
            chk($sformatf("f%0d.byte%0d.stop", fi, b), 32'(obs[b][9]), 32'd1);
            chk($sformatf("f%0d.byte%0d.data", fi, b), 32'(obs[b][8:1]), 32'(v.b[b]));
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.c%0d.tx", tag, i), 32'(tx), 32'd1);
            chk($sformatf("%s.c%0d.busy", tag, i), 32'(busy), 32'd0);
            chk($sformatf("%s.c%0d.drop", tag, i), 32'(drop), 32'd0);
            chk($sformatf("%s.c%0d.frame_done", tag, i), 32'(fdone), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        eos = 1'b0;
        ch0 = '0;
        ch1 = '0;

        vecs[0] = mk(12'hABC, 12'h123, 0,   8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h31);
        vecs[1] = mk(12'hABC, 12'h123, 100, 8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h31);
        // XOR of A5 0F FF 0F FF is A5.
        vecs[2] = mk(12'hFFF, 12'hFFF, 0,   8'hA5, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'hA5);
        vecs[3] = mk(12'h000, 12'h000, 0,   8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5);
        vecs[4] = mk(12'h5A3, 12'h0C6, FRAME_CYC + 1,
                     8'hA5, 8'h05, 8'hA3, 8'h00, 8'hC6, 8'hC5);

        #1;
        chk("rst.tx", 32'(tx), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.drop", 32'(drop), 32'd0);
        chk("rst.frame_done", 32'(fdone), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_check("post_rst", 4);

        // Frames run back-to-back: each eos lands in the first cycle after busy falls.
        for (int f = 0; f < 5; f++) run_frame(vecs[f], f);
        // DONE-cycle eos of the last frame must not start another frame.
        idle_check("no_second", 30);

        // Abandon a frame in the middle of B2's data bits.
        ch0 = 12'hABC;
        ch1 = 12'h123;
        eos = 1'b1;
        for (int p = 1; p <= 90; p++) begin
            @(negedge clk);
            if (p == 1) eos = 1'b0;
        end
        chk("mid.busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst.tx", 32'(tx), 32'd1);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.drop", 32'(drop), 32'd0);
        chk("mid_rst.frame_done", 32'(fdone), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check("after_mid_rst", 5);
        run_frame(mk(12'h000, 12'hFFF, 0, 8'hA5, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h55), 5);
        idle_check("tail", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
